mc_ctrl: RTL and testbench

Multi-cycle control unit for the RV32 subset the datapath implements: I-type ALU (OP-IMM), S-type store, and SB-type branch (BEQ/BNE). It sequences one shared memory port, the instruction register, the ALU and the register file over several cycles per instruction. Each cycle it emits the datapath select and enable signals. The immediate generator decodes its own format from the opcode, so this block never drives an immediate-select signal.

---
 rtl/mc_ctrl_pkg.sv | 51 +++++
 rtl/mc_ctrl_if.sv | 35 +++
 rtl/mc_ctrl_mem_wait_timer.sv | 28 ++
 rtl/mc_ctrl.sv | 155 +++++++++++++++
 tb/tb_mc_ctrl.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared constants, state encoding and instruction classification for the
// multi-cycle RV32 control unit (OP-IMM, SW, BEQ/BNE).
package mc_ctrl_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic PC_SRC_SEQ = 1'b0;
    localparam logic PC_SRC_BR  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_OPIMM  = 2'd1,
        CLS_STORE  = 2'd2,
        CLS_BRANCH = 2'd3
    } instr_class_t;

    // CLS_NONE marks anything the datapath cannot execute; it sends DECODE to TRAP.
    function automatic instr_class_t classify(input logic [6:0] opcode,
                                              input logic [2:0] funct3);
        instr_class_t cls;
        cls = CLS_NONE;
        if (opcode == OP_IMM)
            cls = CLS_OPIMM;
        else if (opcode == OP_STORE && funct3 == F3_SW)
            cls = CLS_STORE;
        else if (opcode == OP_BRANCH && (funct3 == F3_BEQ || funct3 == F3_BNE))
            cls = CLS_BRANCH;
        return cls;
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Control/datapath bundle: IR fields and status in, memory handshake and
// datapath selects/enables out.
interface mc_ctrl_if;
    import mc_ctrl_pkg::*;

    logic [6:0] ir_opcode;
    logic [2:0] ir_funct3;
    logic       alu_zero;
    logic       mem_ready;

    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       pc_write;
    logic       pc_src;
    logic       retire;
    logic       halt;
    logic       bus_err;

    modport master (
        input  ir_opcode, ir_funct3, alu_zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, alu_src_b, alu_op,
               reg_write, pc_write, pc_src, retire, halt, bus_err
    );

    modport slave (
        output ir_opcode, ir_funct3, alu_zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, alu_src_b, alu_op,
               reg_write, pc_write, pc_src, retire, halt, bus_err
    );
endinterface

// File: rtl/mc_ctrl_mem_wait_timer.sv
// Memory wait timer: counts consecutive un-ready cycles in a memory state and
// flags the last cycle allowed before a bus-error trap.
module mc_ctrl_mem_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);
    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] count;

    // Clear wins so the count restarts on every memory-state entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (inc)
            count <= count + 8'd1;
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control unit: sequences fetch, decode, execute, store and
// write-back over a shared memory port, trapping on bad opcodes or timeouts.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 16
) (
    input logic       clk,
    input logic       rst,
    mc_ctrl_if.master bus
);
    state_t       state;
    state_t       next_state;
    instr_class_t cls;
    logic         bus_err_q;
    logic         taken;
    logic         waiting;
    logic         expired;
    logic         timeout;

    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       pc_write;
    logic       pc_src;
    logic       retire;
    logic       halt;
    logic       bus_err;

    assign cls     = classify(bus.ir_opcode, bus.ir_funct3);
    assign taken   = (bus.ir_funct3 == F3_BEQ &&  bus.alu_zero) ||
                     (bus.ir_funct3 == F3_BNE && !bus.alu_zero);
    assign waiting = (state == FETCH || state == MEM) && !bus.mem_ready;

    mc_ctrl_mem_wait_timer #(
        .LIMIT   (WAIT_LIMIT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (next_state != state),
        .inc     (waiting),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bus_err_q <= 1'b0;
        end else begin
            state <= next_state;
            if (timeout)
                bus_err_q <= 1'b1;
        end
    end

    // mem_ready wins over an expiring timer, so a late completion still retires.
    always_comb begin
        next_state = state;
        timeout    = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        alu_src_b  = 1'b0;
        alu_op     = ALU_ADD;
        reg_write  = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_SEQ;
        retire     = 1'b0;
        halt       = 1'b0;
        bus_err    = 1'b0;
        case (state)
            IDLE: next_state = FETCH;
            FETCH: begin
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ir_write   = 1'b1;
                    next_state = DECODE;
                end else if (expired) begin
                    timeout    = 1'b1;
                    next_state = TRAP;
                end
            end
            DECODE: next_state = (cls == CLS_NONE) ? TRAP : EXEC;
            EXEC: begin
                case (cls)
                    CLS_OPIMM: begin
                        alu_src_b  = 1'b1;
                        alu_op     = ALU_FUNCT;
                        next_state = WB;
                    end
                    CLS_STORE: begin
                        alu_src_b  = 1'b1;
                        alu_op     = ALU_ADD;
                        next_state = MEM;
                    end
                    CLS_BRANCH: begin
                        alu_op     = ALU_SUB;
                        pc_write   = 1'b1;
                        pc_src     = taken ? PC_SRC_BR : PC_SRC_SEQ;
                        retire     = 1'b1;
                        next_state = FETCH;
                    end
                    default: next_state = TRAP;
                endcase
            end
            MEM: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                iord      = 1'b1;
                alu_src_b = 1'b1;
                alu_op    = ALU_ADD;
                if (bus.mem_ready) begin
                    pc_write   = 1'b1;
                    pc_src     = PC_SRC_SEQ;
                    retire     = 1'b1;
                    next_state = FETCH;
                end else if (expired) begin
                    timeout    = 1'b1;
                    next_state = TRAP;
                end
            end
            WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                pc_src     = PC_SRC_SEQ;
                retire     = 1'b1;
                next_state = FETCH;
            end
            TRAP: begin
                halt    = 1'b1;
                bus_err = bus_err_q;
            end
            default: next_state = IDLE;
        endcase
    end

    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = mem_we;
    assign bus.iord      = iord;
    assign bus.ir_write  = ir_write;
    assign bus.alu_src_b = alu_src_b;
    assign bus.alu_op    = alu_op;
    assign bus.reg_write = reg_write;
    assign bus.pc_write  = pc_write;
    assign bus.pc_src    = pc_src;
    assign bus.retire    = retire;
    assign bus.halt      = halt;
    assign bus.bus_err   = bus_err;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl (WAIT_LIMIT=4): each cycle's inputs are driven after
// the rising edge and the packed control outputs are checked on the falling edge.
module tb_mc_ctrl;
    import mc_ctrl_pkg::*;

    // Packed order: req we iord irw srcb aluop[1:0] rw pcw pcs ret halt berr
    localparam logic [12:0] E_IDLE       = 13'b0_0_0_0_0_00_0_0_0_0_0_0;
    localparam logic [12:0] E_FETCH_WAIT = 13'b1_0_0_0_0_00_0_0_0_0_0_0;
    localparam logic [12:0] E_FETCH_DONE = 13'b1_0_0_1_0_00_0_0_0_0_0_0;
    localparam logic [12:0] E_DECODE     = 13'b0_0_0_0_0_00_0_0_0_0_0_0;
    localparam logic [12:0] E_EXEC_IMM   = 13'b0_0_0_0_1_10_0_0_0_0_0_0;
    localparam logic [12:0] E_WB         = 13'b0_0_0_0_0_00_1_1_0_1_0_0;
    localparam logic [12:0] E_EXEC_ST    = 13'b0_0_0_0_1_00_0_0_0_0_0_0;
    localparam logic [12:0] E_MEM_WAIT   = 13'b1_1_1_0_1_00_0_0_0_0_0_0;
    localparam logic [12:0] E_MEM_DONE   = 13'b1_1_1_0_1_00_0_1_0_1_0_0;
    localparam logic [12:0] E_BR_TAKEN   = 13'b0_0_0_0_0_01_0_1_1_1_0_0;
    localparam logic [12:0] E_BR_NOT     = 13'b0_0_0_0_0_01_0_1_0_1_0_0;
    localparam logic [12:0] E_TRAP       = 13'b0_0_0_0_0_00_0_0_0_0_1_0;
    localparam logic [12:0] E_TRAP_BUS   = 13'b0_0_0_0_0_00_0_0_0_0_1_1;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    mc_ctrl_if bus_if ();

    mc_ctrl #(
        .WAIT_LIMIT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                                 input logic zero, input logic rdy);
        bus_if.ir_opcode = op;
        bus_if.ir_funct3 = f3;
        bus_if.alu_zero  = zero;
        bus_if.mem_ready = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [12:0] expected);
        logic [12:0] observed;
        observed = {bus_if.mem_req, bus_if.mem_we, bus_if.iord, bus_if.ir_write,
                    bus_if.alu_src_b, bus_if.alu_op, bus_if.reg_write,
                    bus_if.pc_write, bus_if.pc_src, bus_if.retire,
                    bus_if.halt, bus_if.bus_err};
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Entered just after a rising edge; leaves just after the next one.
    task automatic runCycle(input string tag, input logic [6:0] op, input logic [2:0] f3,
                            input logic zero, input logic rdy, input logic [12:0] expected);
        applyStimulus(op, f3, zero, rdy);
        @(negedge clk);
        checkOutput(tag, expected);
        @(posedge clk);
        #1;
    endtask

    // Reset rises mid-cycle; outputs must clear without waiting for a clock edge.
    task automatic doReset(input string tag);
        rst = 1'b1;
        #1;
        checkOutput(tag, E_IDLE);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(7'd0, 3'd0, 1'b0, 1'b0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        applyStimulus(7'd0, 3'd0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("reset_held", E_IDLE);
        @(posedge clk);
        #1;
        rst = 1'b0;

        runCycle("idle", 7'd0, 3'd0, 1'b0, 1'b0, E_IDLE);

        // addi x1,x0,5 with zero-wait memory
        runCycle("addi_fetch",  7'd0,   3'd0, 1'b0, 1'b1, E_FETCH_DONE);
        runCycle("addi_decode", OP_IMM, 3'd0, 1'b0, 1'b0, E_DECODE);
        runCycle("addi_exec",   OP_IMM, 3'd0, 1'b0, 1'b0, E_EXEC_IMM);
        runCycle("addi_wb",     OP_IMM, 3'd0, 1'b0, 1'b0, E_WB);

        // sw x1,8(x0) with two un-ready MEM cycles
        runCycle("sw_fetch",  OP_IMM,   3'd0,  1'b0, 1'b1, E_FETCH_DONE);
        runCycle("sw_decode", OP_STORE, F3_SW, 1'b0, 1'b0, E_DECODE);
        runCycle("sw_exec",   OP_STORE, F3_SW, 1'b0, 1'b0, E_EXEC_ST);
        runCycle("sw_mem_w1", OP_STORE, F3_SW, 1'b0, 1'b0, E_MEM_WAIT);
        runCycle("sw_mem_w2", OP_STORE, F3_SW, 1'b0, 1'b0, E_MEM_WAIT);
        runCycle("sw_mem_ok", OP_STORE, F3_SW, 1'b0, 1'b1, E_MEM_DONE);

        // beq x0,x0,+8 taken, then not taken; bne taken
        runCycle("beq_t_fetch",  OP_STORE,  F3_SW,  1'b1, 1'b1, E_FETCH_DONE);
        runCycle("beq_t_decode", OP_BRANCH, F3_BEQ, 1'b1, 1'b0, E_DECODE);
        runCycle("beq_t_exec",   OP_BRANCH, F3_BEQ, 1'b1, 1'b0, E_BR_TAKEN);
        runCycle("beq_n_fetch",  OP_BRANCH, F3_BEQ, 1'b0, 1'b1, E_FETCH_DONE);
        runCycle("beq_n_decode", OP_BRANCH, F3_BEQ, 1'b0, 1'b0, E_DECODE);
        runCycle("beq_n_exec",   OP_BRANCH, F3_BEQ, 1'b0, 1'b0, E_BR_NOT);
        runCycle("bne_t_fetch",  OP_BRANCH, F3_BEQ, 1'b0, 1'b1, E_FETCH_DONE);
        runCycle("bne_t_decode", OP_BRANCH, F3_BNE, 1'b0, 1'b0, E_DECODE);
        runCycle("bne_t_exec",   OP_BRANCH, F3_BNE, 1'b0, 1'b0, E_BR_TAKEN);

        // Three un-ready fetch cycles, ready on the limit cycle: completes normally
        runCycle("lim_fetch_w1", 7'd0,   3'd0, 1'b0, 1'b0, E_FETCH_WAIT);
        runCycle("lim_fetch_w2", 7'd0,   3'd0, 1'b0, 1'b0, E_FETCH_WAIT);
        runCycle("lim_fetch_w3", 7'd0,   3'd0, 1'b0, 1'b0, E_FETCH_WAIT);
        runCycle("lim_fetch_ok", 7'd0,   3'd0, 1'b0, 1'b1, E_FETCH_DONE);
        runCycle("lim_decode",   OP_IMM, 3'd0, 1'b0, 1'b0, E_DECODE);
        runCycle("lim_exec",     OP_IMM, 3'd0, 1'b0, 1'b0, E_EXEC_IMM);
        runCycle("lim_wb",       OP_IMM, 3'd0, 1'b0, 1'b0, E_WB);

        // Reset in the middle of a store with mem_ready high
        runCycle("rst_sw_fetch",  OP_IMM,   3'd0,  1'b0, 1'b1, E_FETCH_DONE);
        runCycle("rst_sw_decode", OP_STORE, F3_SW, 1'b0, 1'b0, E_DECODE);
        runCycle("rst_sw_exec",   OP_STORE, F3_SW, 1'b0, 1'b0, E_EXEC_ST);
        runCycle("rst_sw_mem_w",  OP_STORE, F3_SW, 1'b0, 1'b0, E_MEM_WAIT);
        applyStimulus(OP_STORE, F3_SW, 1'b0, 1'b1);
        doReset("rst_mid_store");
        runCycle("rst_sw_idle", 7'd0, 3'd0, 1'b0, 1'b0, E_IDLE);

        // Unsupported R-type opcode traps without bus_err and never writes
        runCycle("rtype_fetch",  7'd0,     3'd0, 1'b0, 1'b1, E_FETCH_DONE);
        runCycle("rtype_decode", OP_RTYPE, 3'd0, 1'b0, 1'b0, E_DECODE);
        runCycle("rtype_trap1",  OP_RTYPE, 3'd0, 1'b1, 1'b1, E_TRAP);
        runCycle("rtype_trap2",  OP_IMM,   3'd0, 1'b0, 1'b1, E_TRAP);
        doReset("rst_from_trap");
        runCycle("rtype_idle", 7'd0, 3'd0, 1'b0, 1'b0, E_IDLE);

        // Fetch timeout after four un-ready cycles
        runCycle("to_fetch_w1", 7'd0, 3'd0, 1'b0, 1'b0, E_FETCH_WAIT);
        runCycle("to_fetch_w2", 7'd0, 3'd0, 1'b0, 1'b0, E_FETCH_WAIT);
        runCycle("to_fetch_w3", 7'd0, 3'd0, 1'b0, 1'b0, E_FETCH_WAIT);
        runCycle("to_fetch_w4", 7'd0, 3'd0, 1'b0, 1'b0, E_FETCH_WAIT);
        runCycle("to_trap1",    7'd0, 3'd0, 1'b0, 1'b1, E_TRAP_BUS);
        runCycle("to_trap2",    7'd0, 3'd0, 1'b0, 1'b0, E_TRAP_BUS);
        doReset("rst_from_bus_trap");
        runCycle("post_idle",   7'd0, 3'd0, 1'b0, 1'b0, E_IDLE);
        runCycle("post_fetch",  7'd0, 3'd0, 1'b0, 1'b0, E_FETCH_WAIT);

        // Store timeout: counter restarts on MEM entry, bus_err cleared by earlier reset
        runCycle("sto_fetch",   7'd0,     3'd0,  1'b0, 1'b1, E_FETCH_DONE);
        runCycle("sto_decode",  OP_STORE, F3_SW, 1'b0, 1'b0, E_DECODE);
        runCycle("sto_exec",    OP_STORE, F3_SW, 1'b0, 1'b0, E_EXEC_ST);
        runCycle("sto_mem_w1",  OP_STORE, F3_SW, 1'b0, 1'b0, E_MEM_WAIT);
        runCycle("sto_mem_w2",  OP_STORE, F3_SW, 1'b0, 1'b0, E_MEM_WAIT);
        runCycle("sto_mem_w3",  OP_STORE, F3_SW, 1'b0, 1'b0, E_MEM_WAIT);
        runCycle("sto_mem_w4",  OP_STORE, F3_SW, 1'b0, 1'b0, E_MEM_WAIT);
        runCycle("sto_trap",    OP_STORE, F3_SW, 1'b0, 1'b1, E_TRAP_BUS);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
